// File: rtl/d8m_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d8m_timing_pkg
// Description : Shared FSM state encoding and default 640x480 read timing
//               for the Bayer line-buffer read scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package d8m_timing_pkg;

    // Position counters are wide enough for any line/frame up to 2047.
    localparam int c_CNT_W = 11;

    // Default timing for a standard 640x480 sensor stream.
    localparam int c_H_ACTIVE_DEF = 640;
    localparam int c_V_ACTIVE_DEF = 480;
    localparam int c_H_START_DEF  = 144;
    localparam int c_V_START_DEF  = 35;
    localparam int c_VAL_MIN_DEF  = 3;
    localparam int c_VAL_MAX_DEF  = 637;

    typedef logic [2:0] state_t;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WAIT_VS = 3'd1;
    localparam logic [2:0] c_ST_V_PORCH = 3'd2;
    localparam logic [2:0] c_ST_H_PORCH = 3'd3;
    localparam logic [2:0] c_ST_ACTIVE  = 3'd4;
    localparam logic [2:0] c_ST_H_BLANK = 3'd5;

endpackage
`default_nettype wire

// File: rtl/rd_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : rd_pos_counter
// Description : Saturating column/line position pair. Exposes the next
//               column value so the caller can register derived flags in
//               the same cycle as the column itself.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_pos_counter
    import d8m_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE_DEF,
    parameter int V_ACTIVE = c_V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_xClr,
    input  logic               i_xInc,
    input  logic               i_yClr,
    input  logic               i_yInc,
    output logic [c_CNT_W-1:0] o_xCont,
    output logic [c_CNT_W-1:0] o_yCont,
    output logic [c_CNT_W-1:0] o_xNext
);

    localparam logic [c_CNT_W-1:0] c_X_LAST = c_CNT_W'(H_ACTIVE - 1);
    localparam logic [c_CNT_W-1:0] c_Y_LAST = c_CNT_W'(V_ACTIVE - 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_xCont;
    logic [c_CNT_W-1:0] r_yCont;
    logic [c_CNT_W-1:0] w_yNext;

    // Next position: clear wins over increment, increments stop at the last index.
    always_comb begin
        o_xNext = r_xCont;
        w_yNext = r_yCont;
        if (i_xClr) begin
            o_xNext = '0;
        end else if (i_xInc && (r_xCont < c_X_LAST)) begin
            o_xNext = r_xCont + c_ONE;
        end
        if (i_yClr) begin
            w_yNext = '0;
        end else if (i_yInc && (r_yCont < c_Y_LAST)) begin
            w_yNext = r_yCont + c_ONE;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xCont <= '0;
            r_yCont <= '0;
        end else begin
            r_xCont <= o_xNext;
            r_yCont <= w_yNext;
        end
    end

    assign o_xCont = r_xCont;
    assign o_yCont = r_yCont;

endmodule
`default_nettype wire

// File: rtl/bayer_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bayer_read_scheduler
// Description : Sync-edge driven read scheduler for a Bayer line buffer.
//               Generates read strobes, pixel/line indices, demosaic window
//               enable, frame/line pulses and a sticky sync-fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bayer_read_scheduler
    import d8m_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE_DEF,
    parameter int V_ACTIVE = c_V_ACTIVE_DEF,
    parameter int H_START  = c_H_START_DEF,
    parameter int V_START  = c_V_START_DEF,
    parameter int VAL_MIN  = c_VAL_MIN_DEF,
    parameter int VAL_MAX  = c_VAL_MAX_DEF
) (
    input  logic        VGA_CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic        VGA_VS,
    input  logic        VGA_HS,
    output logic        READ_Request,
    output logic [10:0] X_Cont,
    output logic [10:0] Y_Cont,
    output logic        BIN_EN,
    output logic        FRAME_START,
    output logic        LINE_DONE,
    output logic        SYNC_ERR
);

    localparam logic [c_CNT_W-1:0] c_X_LAST   = c_CNT_W'(H_ACTIVE - 1);
    localparam logic [c_CNT_W-1:0] c_Y_LAST   = c_CNT_W'(V_ACTIVE - 1);
    localparam logic [c_CNT_W-1:0] c_H_LAST   = c_CNT_W'(H_START - 1);
    localparam logic [c_CNT_W-1:0] c_V_LAST   = c_CNT_W'(V_START - 1);
    localparam logic [c_CNT_W-1:0] c_VAL_MIN  = c_CNT_W'(VAL_MIN);
    localparam logic [c_CNT_W-1:0] c_VAL_MAX  = c_CNT_W'(VAL_MAX);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic               r_vsD, r_hsD, r_enD;
    state_t             r_state, w_stateNext;
    logic [c_CNT_W-1:0] r_hCnt, w_hCntNext;
    logic [c_CNT_W-1:0] r_vCnt, w_vCntNext;
    logic               r_read, r_binEn, r_frameStart, r_lineDone, r_syncErr;
    logic               w_vsRise, w_hsRise, w_enFall;
    logic               w_readNext, w_frameStart, w_lineDone, w_errSet, w_advance;
    logic               w_xClr, w_xInc, w_yClr, w_yInc;
    logic [c_CNT_W-1:0] w_xCont, w_yCont, w_xNext;

    // Syncs are active low, so a rising edge marks the end of the sync pulse.
    assign w_vsRise = VGA_VS & ~r_vsD;
    assign w_hsRise = VGA_HS & ~r_hsD;
    assign w_enFall = r_enD & ~ENABLE;

    // Next-state and control decode; VS release is checked before HS.
    always_comb begin
        w_stateNext  = r_state;
        w_hCntNext   = r_hCnt;
        w_vCntNext   = r_vCnt;
        w_readNext   = 1'b0;
        w_frameStart = 1'b0;
        w_lineDone   = 1'b0;
        w_errSet     = 1'b0;
        w_advance    = 1'b0;
        w_xClr       = 1'b0;
        w_xInc       = 1'b0;
        w_yClr       = 1'b0;
        w_yInc       = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (ENABLE) w_stateNext = c_ST_WAIT_VS;
        end else if (w_vsRise && !ENABLE) begin
            w_stateNext = c_ST_IDLE;
        end else if (w_vsRise) begin
            // A VS release mid-frame is a fault but still restarts the frame.
            w_errSet     = (r_state != c_ST_WAIT_VS);
            w_stateNext  = c_ST_V_PORCH;
            w_frameStart = 1'b1;
            w_vCntNext   = '0;
            w_yClr       = 1'b1;
        end else begin
            case (r_state)
                c_ST_WAIT_VS: w_stateNext = c_ST_WAIT_VS;
                c_ST_V_PORCH: begin
                    if (w_hsRise) begin
                        if (r_vCnt == c_V_LAST) begin
                            w_stateNext = c_ST_H_PORCH;
                            w_hCntNext  = '0;
                            w_yClr      = 1'b1;
                        end else begin
                            w_vCntNext = r_vCnt + c_ONE;
                        end
                    end
                end
                c_ST_H_PORCH: begin
                    if (r_hCnt == c_H_LAST) begin
                        w_stateNext = c_ST_ACTIVE;
                        w_xClr      = 1'b1;
                        w_readNext  = 1'b1;
                    end else begin
                        w_hCntNext = r_hCnt + c_ONE;
                    end
                end
                c_ST_ACTIVE: begin
                    if (w_xCont == c_X_LAST) begin
                        w_stateNext = c_ST_H_BLANK;
                        w_lineDone  = 1'b1;
                    end else if (w_hsRise) begin
                        // Early HS: close the line and treat this HS as the next line start.
                        w_errSet   = 1'b1;
                        w_lineDone = 1'b1;
                        w_advance  = 1'b1;
                    end else begin
                        w_xInc     = 1'b1;
                        w_readNext = 1'b1;
                    end
                end
                c_ST_H_BLANK: w_advance = w_hsRise;
                default:      w_stateNext = c_ST_IDLE;
            endcase
            if (w_advance) begin
                if (w_yCont < c_Y_LAST) begin
                    w_yInc      = 1'b1;
                    w_stateNext = c_ST_H_PORCH;
                    w_hCntNext  = '0;
                end else begin
                    w_stateNext = c_ST_WAIT_VS;
                end
            end
        end
    end

    // State, porch counters, edge history and registered outputs.
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vsD        <= 1'b1;
            r_hsD        <= 1'b1;
            r_enD        <= 1'b0;
            r_state      <= c_ST_IDLE;
            r_hCnt       <= '0;
            r_vCnt       <= '0;
            r_read       <= 1'b0;
            r_binEn      <= 1'b0;
            r_frameStart <= 1'b0;
            r_lineDone   <= 1'b0;
            r_syncErr    <= 1'b0;
        end else begin
            r_vsD        <= VGA_VS;
            r_hsD        <= VGA_HS;
            r_enD        <= ENABLE;
            r_state      <= w_stateNext;
            r_hCnt       <= w_hCntNext;
            r_vCnt       <= w_vCntNext;
            r_read       <= w_readNext;
            r_binEn      <= w_readNext && (w_xNext > c_VAL_MIN) && (w_xNext < c_VAL_MAX);
            r_frameStart <= w_frameStart;
            r_lineDone   <= w_lineDone;
            if (w_enFall) begin
                r_syncErr <= 1'b0;
            end else if (w_errSet) begin
                r_syncErr <= 1'b1;
            end
        end
    end

    rd_pos_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pos (
        .clk     (VGA_CLK),
        .rst_n   (RESET_N),
        .i_xClr  (w_xClr),
        .i_xInc  (w_xInc),
        .i_yClr  (w_yClr),
        .i_yInc  (w_yInc),
        .o_xCont (w_xCont),
        .o_yCont (w_yCont),
        .o_xNext (w_xNext)
    );

    assign READ_Request = r_read;
    assign X_Cont       = w_xCont;
    assign Y_Cont       = w_yCont;
    assign BIN_EN       = r_binEn;
    assign FRAME_START  = r_frameStart;
    assign LINE_DONE    = r_lineDone;
    assign SYNC_ERR     = r_syncErr;

endmodule
`default_nettype wire

// File: tb/tb_bayer_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bayer_read_scheduler
// Description : Directed self-checking bench for bayer_read_scheduler using
//               a reduced 16x6 geometry (H_START=4, V_START=2, window 4..12).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bayer_read_scheduler;

    localparam int c_HA  = 16;
    localparam int c_VA  = 6;
    localparam int c_HS0 = 4;
    localparam int c_VS0 = 2;
    localparam int c_HI  = 26;

    logic        clk = 1'b0;
    logic        rstN, enable, vs, hs;
    logic        readReq, binEn, frameStart, lineDone, syncErr;
    logic [10:0] xCont, yCont;

    int nComp = 0;
    int nFail = 0;
    int fsCnt = 0, ldCnt = 0, rdCnt = 0, binCnt = 0;
    int lastX = 0, lastY = 0;
    int fsB, ldB, rdB, binB;

    bayer_read_scheduler #(
        .H_ACTIVE (c_HA),
        .V_ACTIVE (c_VA),
        .H_START  (c_HS0),
        .V_START  (c_VS0),
        .VAL_MIN  (3),
        .VAL_MAX  (13)
    ) dut (
        .VGA_CLK      (clk),
        .RESET_N      (rstN),
        .ENABLE       (enable),
        .VGA_VS       (vs),
        .VGA_HS       (hs),
        .READ_Request (readReq),
        .X_Cont       (xCont),
        .Y_Cont       (yCont),
        .BIN_EN       (binEn),
        .FRAME_START  (frameStart),
        .LINE_DONE    (lineDone),
        .SYNC_ERR     (syncErr)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the active edge (pre-update values).
    always @(posedge clk) begin
        if (frameStart) fsCnt++;
        if (lineDone)   ldCnt++;
        if (binEn)      binCnt++;
        if (readReq) begin
            rdCnt++;
            lastX = int'(xCont);
            lastY = int'(yCont);
        end
    end

    // Run-time bound.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsRelease();
        vs = 1'b0;
        tick(2);
        vs = 1'b1;
    endtask

    task automatic hsRelease();
        hs = 1'b0;
        tick(2);
        hs = 1'b1;
    endtask

    task automatic line();
        hsRelease();
        tick(c_HI);
    endtask

    task automatic frameHead();
        vsRelease();
        tick(4);
        repeat (c_VS0 - 1) line();
    endtask

    task automatic snap();
        fsB  = fsCnt;
        ldB  = ldCnt;
        rdB  = rdCnt;
        binB = binCnt;
    endtask

    initial begin
        rstN = 1'b0; enable = 1'b0; vs = 1'b1; hs = 1'b1;
        tick(3);
        // Reset state
        check("rst_read",  int'(readReq), 0);
        check("rst_x",     int'(xCont), 0);
        check("rst_y",     int'(yCont), 0);
        check("rst_bin",   int'(binEn), 0);
        check("rst_fs",    int'(frameStart), 0);
        check("rst_ld",    int'(lineDone), 0);
        check("rst_err",   int'(syncErr), 0);

        // No partial frame before a VS release
        rstN = 1'b1;
        tick(1);
        enable = 1'b1;
        tick(2);
        line();
        line();
        check("nopartial_reads", rdCnt, 0);
        check("nopartial_ld",    ldCnt, 0);

        // Full frame with directed window checks on line 0
        snap();
        frameHead();
        hsRelease();
        tick(5);
        check("l0_x0",      int'(xCont), 0);
        check("l0_read0",   int'(readReq), 1);
        check("l0_y0",      int'(yCont), 0);
        check("l0_bin_x0",  int'(binEn), 0);
        tick(3);
        check("l0_x3",      int'(xCont), 3);
        check("l0_bin_x3",  int'(binEn), 0);
        tick(1);
        check("l0_bin_x4",  int'(binEn), 1);
        tick(8);
        check("l0_x12",     int'(xCont), 12);
        check("l0_bin_x12", int'(binEn), 1);
        tick(1);
        check("l0_bin_x13", int'(binEn), 0);
        tick(2);
        check("l0_x15",     int'(xCont), 15);
        check("l0_read15",  int'(readReq), 1);
        tick(1);
        check("l0_ld",      int'(lineDone), 1);
        check("l0_readoff", int'(readReq), 0);
        check("l0_xhold",   int'(xCont), 15);
        tick(1);
        check("l0_ld_once", int'(lineDone), 0);
        tick(4);
        repeat (c_VA - 1) line();
        line();
        check("f1_fs",    fsCnt - fsB, 1);
        check("f1_ld",    ldCnt - ldB, 6);
        check("f1_reads", rdCnt - rdB, 96);
        check("f1_bin",   binCnt - binB, 54);
        check("f1_lastx", lastX, 15);
        check("f1_lasty", lastY, 5);
        check("f1_xsat",  int'(xCont), 15);
        check("f1_ysat",  int'(yCont), 5);
        check("f1_err",   int'(syncErr), 0);

        // VS release injected mid-line at Y=3
        frameHead();
        repeat (3) line();
        hsRelease();
        tick(10);
        check("vse_pre_y",    int'(yCont), 3);
        check("vse_pre_x",    int'(xCont), 5);
        vs = 1'b0;
        tick(2);
        vs = 1'b1;
        tick(1);
        check("vse_err",  int'(syncErr), 1);
        check("vse_read", int'(readReq), 0);
        check("vse_fs",   int'(frameStart), 1);
        check("vse_y",    int'(yCont), 0);

        // Falling ENABLE clears the sticky fault
        enable = 1'b0;
        tick(1);
        check("enfall_clr", int'(syncErr), 0);
        enable = 1'b1;
        tick(2);

        // HS release injected mid-line at Y=2, X=5
        line();
        line();
        line();
        hsRelease();
        tick(10);
        check("hse_pre_y", int'(yCont), 2);
        hs = 1'b0;
        tick(2);
        hs = 1'b1;
        tick(1);
        check("hse_err",  int'(syncErr), 1);
        check("hse_ld",   int'(lineDone), 1);
        check("hse_read", int'(readReq), 0);
        check("hse_x",    int'(xCont), 7);
        tick(4);
        check("hse_next_read", int'(readReq), 1);
        check("hse_next_x",    int'(xCont), 0);
        check("hse_next_y",    int'(yCont), 3);
        tick(21);
        repeat (2) line();
        line();

        // ENABLE dropped at Y=2: frame completes, then IDLE at next VS
        snap();
        frameHead();
        line();
        line();
        hsRelease();
        tick(10);
        enable = 1'b0;
        tick(1);
        check("endrop_err", int'(syncErr), 0);
        tick(16);
        repeat (3) line();
        line();
        check("endrop_ld",    ldCnt - ldB, 6);
        check("endrop_reads", rdCnt - rdB, 96);
        vsRelease();
        tick(1);
        check("endrop_nofs", int'(frameStart), 0);
        snap();
        repeat (3) line();
        check("idle_reads", rdCnt - rdB, 0);
        check("idle_fs",    fsCnt - fsB, 0);

        // Asynchronous reset mid-line at X=5
        enable = 1'b1;
        tick(2);
        frameHead();
        hsRelease();
        tick(10);
        check("arst_pre_read", int'(readReq), 1);
        #2;
        rstN = 1'b0;
        #1;
        check("arst_read", int'(readReq), 0);
        check("arst_x",    int'(xCont), 0);
        check("arst_y",    int'(yCont), 0);
        check("arst_bin",  int'(binEn), 0);
        tick(2);
        rstN = 1'b1;
        tick(2);
        snap();
        repeat (3) line();
        check("arst_noreads", rdCnt - rdB, 0);
        frameHead();
        line();
        check("arst_fs",    fsCnt - fsB, 1);
        check("arst_reads", rdCnt - rdB, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bayer_read_scheduler.md
BAYER_READ_SCHEDULER -- requirements
Module: bayer_read_scheduler

Interface
REQ-001 SHALL have parameters: H_ACTIVE, default 640, active pixels per line; V_ACTIVE, default 480, active lines per frame; H_START, default 144, clocks from HS release to first active pixel; V_START, default 35, lines from VS release to first active line; VAL_MIN, default 3, first valid demosaic column; VAL_MAX, default 637, last valid demosaic column plus one.
REQ-002 SHALL have ports (name, direction, width, meaning):
- VGA_CLK, in, 1: pixel clock; the only clock.
- RESET_N, in, 1: asynchronous active-low reset.
- ENABLE, in, 1: frame-level run enable.
- VGA_VS, in, 1: vertical sync, active low.
- VGA_HS, in, 1: horizontal sync, active low.
- READ_Request, out, 1: line-buffer read strobe.
- X_Cont, out, 11: active column index.
- Y_Cont, out, 11: active line index.
- BIN_EN, out, 1: demosaic enable, high only inside the valid column window.
- FRAME_START, out, 1: one-cycle pulse at frame begin.
- LINE_DONE, out, 1: one-cycle pulse after the last read of a line.
- SYNC_ERR, out, 1: sticky timing-fault flag.

Function
REQ-003 SHALL detect HS and VS rising edges (sync release) using one register stage per sync; all detection is edge-based.
REQ-004 SHALL run an FSM with states IDLE, WAIT_VS, V_PORCH, H_PORCH, ACTIVE, H_BLANK.
REQ-005 IDLE->WAIT_VS when ENABLE=1; from any state, ENABLE=0 SHALL move the FSM to IDLE at the next VS release.
REQ-006 WAIT_VS->V_PORCH on VS release; FRAME_START SHALL pulse in that same cycle; the line counter clears.
REQ-007 V_PORCH SHALL count HS releases; on the V_START-th release it SHALL enter H_PORCH with Y_Cont=0.
REQ-008 H_PORCH SHALL count clocks from HS release; after H_START clocks it SHALL enter ACTIVE with X_Cont=0.
REQ-009 In ACTIVE, READ_Request=1 and X_Cont SHALL increment by one per clock from 0 to H_ACTIVE-1.
REQ-010 After X_Cont=H_ACTIVE-1, the FSM SHALL enter H_BLANK; READ_Request=0; LINE_DONE SHALL pulse for one cycle; X_Cont holds.
REQ-011 In H_BLANK, on HS release: if Y_Cont<V_ACTIVE-1, Y_Cont increments and the FSM enters H_PORCH; otherwise the FSM enters WAIT_VS.
REQ-012 BIN_EN SHALL equal READ_Request AND (X_Cont>VAL_MIN) AND (X_Cont<VAL_MAX), registered together with X_Cont with zero relative skew.
REQ-013 X_Cont[0] and Y_Cont[0] SHALL give the Bayer phase directly; X_Cont and Y_Cont SHALL never wrap past H_ACTIVE-1 or V_ACTIVE-1.
REQ-014 VS release in any state other than IDLE or WAIT_VS SHALL set SYNC_ERR, drop READ_Request, and restart as in REQ-006 in the same cycle.
REQ-015 HS release during ACTIVE SHALL set SYNC_ERR, end the line as in REQ-010, then proceed as in REQ-011.
REQ-016 SYNC_ERR SHALL clear only on reset or when ENABLE falls.
REQ-017 When VS and HS release in the same cycle, VS SHALL take priority.

Reset
REQ-018 Asserting RESET_N low at any time SHALL force: FSM=IDLE, all counters=0, READ_Request=0, BIN_EN=0, FRAME_START=0, LINE_DONE=0, SYNC_ERR=0, X_Cont=0, Y_Cont=0.
REQ-019 After RESET_N rises, the first frame SHALL start only at a VS release observed after ENABLE=1; no partial frame is read.

Structure
REQ-020 FSM state encoding and the default timing constants SHALL live in a shared package, d8m_timing_pkg.
REQ-021 The horizontal/vertical counter pair SHALL be one sub-module, rd_pos_counter; edge detection and the FSM stay in the top level.

Verification
REQ-022 Reset then ENABLE=1 with one standard 640x480 frame -> exactly one FRAME_START; 480 LINE_DONE pulses; 640 READ_Request cycles per line; last values X=639, Y=479.
REQ-023 Single line check -> BIN_EN high for X=4..636 only (633 cycles); low at X=3 and X=637.
REQ-024 VS release injected at Y=100 -> SYNC_ERR=1; READ_Request=0 the next cycle; FRAME_START pulses; Y restarts at 0.
REQ-025 HS release injected at X=300 -> SYNC_ERR=1; LINE_DONE pulses; next line has Y incremented by one.
REQ-026 RESET_N low mid-line at X=200 -> all outputs 0 immediately with no clock edge; no reads until the next VS release.
REQ-027 ENABLE dropped at Y=10 -> current frame completes; FSM stays in IDLE at the next VS; SYNC_ERR cleared.
